regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register bank's single write port (reg_write / write_addr / data_in) among three writeback sources: 0 = ALU, 1 = LOAD, 2 = MULDIV.
- Each source feeds a small FIFO. A round-robin arbiter drains the FIFOs into a registered write stage.
- A 32-bit pending-write mask goes to the hazard unit, which stalls reads of registers that have an uncommitted write.

Parameters:
- DEPTH, 2, entries per source FIFO (power of two, 2..8).
- NSRC, 3, number of sources (fixed at 3; not for override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- src_valid  in  3  per-source write request; bit i = source i.
- src_ready  out  3  per-source accept.
- src_addr  in  15  per-source destination register; [5i+4:5i] = source i.
- src_data  in  96  per-source write data; [32i+31:32i] = source i.
- reg_write  out  1  write enable to register bank.
- write_addr  out  5  register bank write address.
- data_in  out  32  register bank write data.
- wr_src  out  2  source index of the current write (debug).
- busy_mask  out  32  bit r = 1 while any write to register r is queued or in the write stage.

Behaviour:
- Reset: while rst_n = 0 at a rising edge:
  - all FIFOs flushed, counts = 0, rr_ptr = 0.
  - reg_write = 0, write_addr = 0, data_in = 0, wr_src = 0.
  - busy_mask = 0 and src_ready = 0 in the following cycle.
  - Reset mid-operation discards all queued writes; none reach the bank.
- Accept rule:
  - src_ready[i] = rst_n_q & (count_i < DEPTH). rst_n_q is the rst_n value registered at the previous edge.
  - src_ready depends only on registered state. There is no combinational path from src_valid or the grant to src_ready.
  - A transfer occurs at an edge where src_valid[i] & src_ready[i].
- Register 0: a transfer with addr = 0 is accepted normally but discarded. It is not enqueued, never granted, and never shown in busy_mask. busy_mask[0] = 0 always.
- FIFO:
  - Per-source, DEPTH entries of {addr, data}, in order within a source.
  - Enqueue and dequeue in the same cycle are legal at any count. On a full FIFO, src_ready was already 0, so no enqueue occurs.
  - Pointers wrap modulo DEPTH.
- Arbitration:
  - Evaluated every cycle over non-empty FIFOs.
  - Search order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first non-empty source wins.
  - On a grant to source g: rr_ptr <= (g+1) mod 3, and the head of FIFO g is dequeued.
  - No grant when all FIFOs are empty; rr_ptr holds.
- Write stage:
  - Registered. At the edge after a grant: reg_write = 1, write_addr/data_in = head entry, wr_src = g.
  - With no grant: reg_write = 0, and write_addr/data_in/wr_src hold their previous values.
  - At most one bank write per cycle.
- Latency, uncontended source: accepted at edge E0, granted in the cycle after E0, reg_write high for the cycle following edge E1.
  - Throughput: 1 write/cycle aggregate.
  - Under continuous contention each source gets at least 1 write per 3 cycles.
- busy_mask: bit r set if any valid FIFO entry has addr r, or reg_write = 1 with write_addr = r.
  - Computed from registered state only.
  - A write just accepted at edge E appears in busy_mask in the cycle after E.
- Ordering:
  - Order across sources to the same register is not guaranteed. The hazard unit must not issue a second write to a register whose busy_mask bit is set.
  - The arbiter itself performs no cross-source ordering check.

Test Plan:
- Reset flush: fill LOAD FIFO with 2 entries (addr 5, 6), drop rst_n for 1 cycle -> reg_write stays 0, busy_mask = 0, src_ready = 0 for one cycle, then 3'b111.
- Single write: ALU valid 1 cycle, addr 7, data 0xDEADBEEF -> reg_write = 1 exactly one cycle, write_addr = 7, data_in = 0xDEADBEEF, wr_src = 0, 2 edges after acceptance.
- Round-robin: all three sources continuously valid, distinct addrs -> wr_src sequence 0,1,2,0,1,2; each FIFO never stays full more than 3 cycles.
- Backpressure (DEPTH = 2): MULDIV and LOAD always valid, ALU valid 6 cycles -> ALU src_ready drops to 0 after 2 unserviced entries; no entry lost or duplicated; per-source data order preserved.
- $zero drop: LOAD writes addr 0 data 0x1234 -> src_ready = 1, transfer accepted, reg_write never asserted, busy_mask[0] = 0.
- busy_mask tracking: LOAD writes addr 9 while ALU and MULDIV saturate the port -> busy_mask[9] = 1 from the cycle after acceptance until the cycle after its reg_write pulse, then 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register bank write port among ALU, LOAD and MULDIV
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int NSRC  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  src_valid,
  output logic [2:0]  src_ready,
  input  logic [14:0] src_addr,
  input  logic [95:0] src_data,
  output logic        reg_write,
  output logic [4:0]  write_addr,
  output logic [31:0] data_in,
  output logic [1:0]  wr_src,
  output logic [31:0] busy_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [4:0]  fifo_addr [NSRC][DEPTH];
  logic [31:0] fifo_data [NSRC][DEPTH];
  logic [PW-1:0] wptr [NSRC];
  logic [PW-1:0] rptr [NSRC];
  logic [PW:0]   count [NSRC];

  logic        rst_n_q;
  logic [1:0]  rr_ptr;
  logic        grant_vld;
  logic [1:0]  grant;
  logic [2:0]  push;
  logic [2:0]  pop;
  logic [2:0]  cand;
  logic [PW-1:0] off;

  // Ready comes from registered state only; writes to $zero are accepted but never enqueued.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_ready[i] = rst_n_q & (count[i] < FULL);
      push[i]      = src_valid[i] & src_ready[i] & (src_addr[5*i +: 5] != 5'd0);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant     = rr_ptr;
    cand      = 3'd0;
    for (int k = 0; k < NSRC; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_vld && (count[cand[1:0]] != '0)) begin
        grant_vld = 1'b1;
        grant     = cand[1:0];
      end
    end
    for (int i = 0; i < NSRC; i++) pop[i] = grant_vld && (grant == 2'(i));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        fifo_addr[i][wptr[i]] <= src_addr[5*i +: 5];
        fifo_data[i][wptr[i]] <= src_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q    <= 1'b0;
      rr_ptr     <= 2'd0;
      reg_write  <= 1'b0;
      write_addr <= 5'd0;
      data_in    <= 32'd0;
      wr_src     <= 2'd0;
      for (int i = 0; i < NSRC; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      rst_n_q <= 1'b1;
      if (grant_vld) begin
        rr_ptr     <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
        reg_write  <= 1'b1;
        write_addr <= fifo_addr[grant][rptr[grant]];
        data_in    <= fifo_data[grant][rptr[grant]];
        wr_src     <= grant;
      end else begin
        reg_write  <= 1'b0;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        unique case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Slot k is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    busy_mask = 32'd0;
    off       = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        off = PW'(k) - rptr[i];
        if ({1'b0, off} < count[i]) busy_mask[fifo_addr[i][k]] = 1'b1;
      end
    end
    if (reg_write) busy_mask[write_addr] = 1'b1;
    busy_mask[0] = 1'b0;
  end

endmodule
